// File: rtl/load_store_queue_pkg.sv
// Shared types for the load/store queue: controller states and memory-port opcodes.
package lsq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_RD = 2'd1,
    ST_WR = 2'd2
  } lsq_state_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/load_store_queue_if.sv
// Bundle of the store/load handshakes, load response, memory port and queue status.
interface load_store_queue_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_resp_valid;
  logic [DATA_W-1:0] ld_resp_data;
  logic              ld_resp_fwd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              store_commit;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack, mem_rdata,
    input  st_ready, ld_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd,
           mem_req, mem_we, mem_addr, mem_wdata, store_commit, count, full, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack, mem_rdata,
    output st_ready, ld_ready, ld_resp_valid, ld_resp_data, ld_resp_fwd,
           mem_req, mem_we, mem_addr, mem_wdata, store_commit, count, full, empty
  );

endinterface

// File: rtl/load_store_queue_fwd_search.sv
// Youngest-first address match over the queued stores, used for store-to-load forwarding.
module lsq_fwd_search #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W-1:0]  tail,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] idx_s;
  logic             match_s;
  logic             done_s;

  // Walk from tail-1 back to head; the first valid match found is the youngest store.
  always_comb begin
    hit     = 1'b0;
    data    = {DATA_W{1'b0}};
    done_s  = 1'b0;
    match_s = 1'b0;
    idx_s   = tail;
    for (int k = 1; k <= DEPTH; k++) begin
      idx_s   = tail - PTR_W'(k);
      match_s = !done_s && entry_valid[idx_s] && (entry_addr[idx_s] == ld_addr);
      data    = match_s ? entry_data[idx_s] : data;
      hit     = hit | match_s;
      done_s  = done_s | match_s | (idx_s == head);
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order store queue with store-to-load forwarding sharing one request/acknowledge memory port.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input logic                clk,
  input logic                reset,
  load_store_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  lsq_state_e        state_r;
  lsq_state_e        state_s;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_s;
  logic              full_r;
  logic              empty_r;
  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] entry_addr_r [DEPTH];
  logic [DATA_W-1:0] entry_data_r [DEPTH];
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              resp_valid_r;
  logic              resp_valid_s;
  logic [DATA_W-1:0] resp_data_r;
  logic [DATA_W-1:0] resp_data_s;
  logic              resp_fwd_r;
  logic              resp_fwd_s;
  logic              commit_r;
  logic              push_s;
  logic              pop_s;
  logic              ld_ready_s;
  logic              ld_acc_s;
  logic              fwd_hit_s;
  logic [DATA_W-1:0] fwd_data_s;

  // Readiness comes from registered state only; a same-cycle drain never opens a slot.
  assign push_s     = bus.st_valid & ~full_r;
  assign ld_ready_s = (state_r == IDLE) & ~full_r;
  assign ld_acc_s   = bus.ld_valid & ld_ready_s;

  lsq_fwd_search #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fwd_search (
    .entry_addr  (entry_addr_r),
    .entry_data  (entry_data_r),
    .entry_valid (valid_r),
    .head        (head_r),
    .tail        (tail_r),
    .ld_addr     (bus.ld_addr),
    .hit         (fwd_hit_s),
    .data        (fwd_data_s)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, memory request latch and load response; an accepted load outranks a drain.
  always_comb begin
    state_s      = state_r;
    pop_s        = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    resp_valid_s = 1'b0;
    resp_data_s  = resp_data_r;
    resp_fwd_s   = resp_fwd_r;
    case (state_r)
      IDLE: begin
        if (ld_acc_s) begin
          if (fwd_hit_s) begin
            resp_valid_s = 1'b1;
            resp_data_s  = fwd_data_s;
            resp_fwd_s   = 1'b1;
          end else begin
            state_s    = LD_RD;
            mem_addr_s = bus.ld_addr;
          end
        end else if (!empty_r) begin
          state_s     = ST_WR;
          mem_addr_s  = entry_addr_r[head_r];
          mem_wdata_s = entry_data_r[head_r];
        end else begin
          state_s = IDLE;
        end
      end
      LD_RD: begin
        if (bus.mem_ack) begin
          resp_valid_s = 1'b1;
          resp_data_s  = bus.mem_rdata;
          resp_fwd_s   = 1'b0;
          state_s      = IDLE;
        end else begin
          state_s = LD_RD;
        end
      end
      ST_WR: begin
        if (bus.mem_ack) begin
          pop_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = ST_WR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Pointers, occupancy flags, valid bits and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {(PTR_W+1){1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      valid_r      <= {DEPTH{1'b0}};
      commit_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_W{1'b0}};
      resp_fwd_r   <= 1'b0;
    end else begin
      if (push_s) begin
        tail_r          <= tail_r + PTR_ONE;
        valid_r[tail_r] <= 1'b1;
      end
      if (pop_s) begin
        head_r          <= head_r + PTR_ONE;
        valid_r[head_r] <= 1'b0;
      end
      count_r      <= count_s;
      full_r       <= (count_s == CNT_DEPTH);
      empty_r      <= (count_s == {(PTR_W+1){1'b0}});
      commit_r     <= pop_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_fwd_r   <= resp_fwd_s;
    end
  end

  // Entry payload; contents of free slots are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entry_addr_r[tail_r] <= bus.st_addr;
      entry_data_r[tail_r] <= bus.st_data;
    end
  end

  assign bus.st_ready      = ~full_r;
  assign bus.ld_ready      = ld_ready_s;
  assign bus.ld_resp_valid = resp_valid_r;
  assign bus.ld_resp_data  = resp_data_r;
  assign bus.ld_resp_fwd   = resp_fwd_r;
  assign bus.mem_req       = (state_r != IDLE);
  assign bus.mem_we        = (state_r == ST_WR) ? MEM_WR : MEM_RD;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.store_commit  = commit_r;
  assign bus.count         = count_r;
  assign bus.full          = full_r;
  assign bus.empty         = empty_r;

endmodule

// File: tb/tb_load_store_queue.sv
// Randomised scoreboard bench for load_store_queue against a program-order memory model.
module tb_load_store_queue;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  load_store_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [11:0] addr; logic [15:0] data; } st_t;
  typedef struct { logic [15:0] data; logic fwd; int due; } resp_t;

  st_t         sq[$];          // stores accepted but not yet written to memory
  resp_t       exp_resp[$];
  logic [15:0] arch_mem [logic [11:0]];  // value a load must observe (program order)
  logic [15:0] mem      [logic [11:0]];  // what the memory actually holds

  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  int   commit_edge = -1;
  int   n_commits = 0;
  int   ack_mode = 1;
  int   lat_cnt = -1;
  bit   last_ld_acc = 1'b0;
  logic [11:0] rd_addr_exp = 12'h000;
  resp_t mon_e;
  logic        p_req = 1'b0;
  logic        p_we = 1'b0;
  logic [11:0] p_addr = 12'h000;
  logic [15:0] p_wdata = 16'h0000;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [15:0] init_val(logic [11:0] a);
    return {4'hA, a} ^ 16'h35C3;
  endfunction

  function automatic logic [15:0] mem_val(logic [11:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] arch_val(logic [11:0] a);
    if (arch_mem.exists(a)) return arch_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: responses, queue status and request stability, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      p_req = 1'b0;
    end else begin
      if (bus.ld_resp_valid) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          mon_e = exp_resp.pop_front();
          chk("resp_data", 32'(bus.ld_resp_data), 32'(mon_e.data));
          chk("resp_fwd", 32'(bus.ld_resp_fwd), 32'(mon_e.fwd));
          chk("resp_cycle", 32'(edge_n), 32'(mon_e.due));
        end
      end else if (exp_resp.size() != 0 && exp_resp[0].due != 0 && exp_resp[0].due <= edge_n) begin
        chk("missing_resp", 32'd0, 32'd1);
        void'(exp_resp.pop_front());
      end
      chk("count", 32'(bus.count), 32'(sq.size()));
      chk("full", 32'(bus.full), 32'(sq.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(sq.size() == 0));
      chk("st_ready", 32'(bus.st_ready), 32'(sq.size() != DEPTH));
      chk("store_commit", 32'(bus.store_commit), 32'(edge_n == commit_edge));
      chk("ld_ready", 32'(bus.ld_ready), 32'(!bus.mem_req && sq.size() != DEPTH));
      if (p_req && !bus.mem_ack) begin
        chk("req_held", 32'(bus.mem_req), 32'd1);
        chk("we_held", 32'(bus.mem_we), 32'(p_we));
        chk("addr_held", 32'(bus.mem_addr), 32'(p_addr));
        if (p_we) chk("wdata_held", 32'(bus.mem_wdata), 32'(p_wdata));
      end
      p_req   = bus.mem_req;
      p_we    = bus.mem_we;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
    end
  end

  // One clock of stimulus plus the memory responder; model updates describe the coming edge.
  task automatic cycle(input bit sv, input logic [11:0] sa, input logic [15:0] sd,
                       input bit lv, input logic [11:0] la);
    bit st_acc, ld_acc, wr_ack, rd_ack;
    resp_t r;
    st_t s;
    bus.st_valid  = sv;
    bus.st_addr   = sa;
    bus.st_data   = sd;
    bus.ld_valid  = lv;
    bus.ld_addr   = la;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    if (bus.mem_req && ack_mode != 0) begin
      if (lat_cnt < 0) lat_cnt = (ack_mode == 1) ? int'($urandom_range(0, 3)) : ((ack_mode == 2) ? 3 : 0);
      if (lat_cnt == 0) begin
        bus.mem_ack = 1'b1;
        lat_cnt = -1;
        if (!bus.mem_we) bus.mem_rdata = mem_val(bus.mem_addr);
      end else begin
        lat_cnt--;
      end
    end
    #1;
    st_acc = sv && bus.st_ready;
    ld_acc = lv && bus.ld_ready;
    wr_ack = bus.mem_req && bus.mem_we && bus.mem_ack;
    rd_ack = bus.mem_req && !bus.mem_we && bus.mem_ack;
    if (wr_ack) begin
      if (sq.size() == 0) begin
        chk("spurious_write", 32'd1, 32'd0);
      end else begin
        s = sq.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(s.addr));
        chk("wr_data", 32'(bus.mem_wdata), 32'(s.data));
      end
      mem[bus.mem_addr] = bus.mem_wdata;
      commit_edge = edge_n + 1;
      n_commits++;
    end
    if (rd_ack) begin
      chk("rd_addr", 32'(bus.mem_addr), 32'(rd_addr_exp));
      if (exp_resp.size() == 0) begin
        chk("spurious_read", 32'd1, 32'd0);
      end else begin
        r = exp_resp.pop_back();
        r.due = edge_n + 1;
        exp_resp.push_back(r);
      end
    end
    if (ld_acc) begin
      r.fwd = 1'b0;
      foreach (sq[i]) if (sq[i].addr == la) r.fwd = 1'b1;
      r.data = arch_val(la);
      r.due  = r.fwd ? edge_n + 1 : 0;
      exp_resp.push_back(r);
      rd_addr_exp = la;
    end
    if (st_acc) begin
      s.addr = sa;
      s.data = sd;
      sq.push_back(s);
      arch_mem[sa] = sd;
    end
    last_ld_acc = ld_acc;
    @(negedge clk);
    #1;
  endtask

  task automatic load_wait(input logic [11:0] la, input bit sv);
    bit acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      cycle(sv, 12'h030, 16'h3030, 1'b1, la);
      acc = last_ld_acc;
    end
    chk("load_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    while ((sq.size() != 0 || exp_resp.size() != 0 || bus.mem_req) && k < max_cycles) begin
      cycle(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000);
      k++;
    end
    chk("drain_done", 32'(sq.size() == 0 && exp_resp.size() == 0 && !bus.mem_req), 32'd1);
  endtask

  initial begin
    bus.st_valid = 1'b0; bus.st_addr = 12'h000; bus.st_data = 16'h0000;
    bus.ld_valid = 1'b0; bus.ld_addr = 12'h000;
    bus.mem_ack  = 1'b0; bus.mem_rdata = 16'h0000;
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_resp_valid", 32'(bus.ld_resp_valid), 32'd0);
    chk("rst_commit", 32'(bus.store_commit), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;

    // Fill with the memory stalled; the ninth store must bounce.
    ack_mode = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 12'h010 + 12'(i), 16'h0A00 + 16'(i), 1'b0, 12'h000);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_st_ready", 32'(bus.st_ready), 32'd0);
    cycle(1'b1, 12'h018, 16'h0A08, 1'b0, 12'h000);
    chk("ninth_rejected", 32'(bus.count), 32'd8);

    // Full queue with a competing load: the head store drains before the load is taken.
    chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("full_st_ready", 32'(bus.st_ready), 32'd0);
    ack_mode = 1;
    n_commits = 0;
    load_wait(12'h013, 1'b1);
    chk("drain_before_load", 32'(n_commits > 0), 32'd1);
    drain(300);

    // Two stores to one address, load forwards the younger.
    ack_mode = 2;
    cycle(1'b1, 12'h020, 16'h1111, 1'b0, 12'h000);
    cycle(1'b1, 12'h020, 16'h2222, 1'b0, 12'h000);
    load_wait(12'h020, 1'b0);
    drain(100);

    // Miss served by memory with three stall cycles.
    mem[12'h055] = 16'hBEEF;
    arch_mem[12'h055] = 16'hBEEF;
    load_wait(12'h055, 1'b0);
    drain(100);

    // Three stores, memory acks every request at once.
    ack_mode = 3;
    n_commits = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'h040 + 12'(i), 16'h4400 + 16'(i), 1'b0, 12'h000);
    drain(100);
    chk("three_commits", 32'(n_commits), 32'd3);
    chk("three_empty", 32'(bus.empty), 32'd1);

    // Reset while a read is outstanding.
    ack_mode = 0;
    load_wait(12'h077, 1'b0);
    cycle(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000);
    chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    sq.delete();
    exp_resp.delete();
    arch_mem = mem;
    lat_cnt = -1;
    commit_edge = -1;
    cycle(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000);
    cycle(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000);
    reset = 1'b1;
    ack_mode = 1;
    for (int i = 0; i < 6; i++) cycle(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000);

    // Random mix over a small address window so hits and misses both occur.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), 12'h020 + 12'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 9) < 4), 12'h020 + 12'($urandom_range(0, 9)));
    end
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
